ram_arbiter: RTL and testbench
==============================

// Module: ram_arbiter
// PURPOSE
// - Owns the shared SRAM port; turns the slot strobes of the cycle scheduler (CPU slot, Wishbone slots) into SRAM cycles.
// - CPU slot: one unconditional access for the CPU. WB slot: serves one pending Wishbone master (2, round-robin).
// - Sits between the timing scheduler, the CPU bus interface, the Wishbone masters and the SRAM pins.
// PARAMETERS
// ACCESS_CYCLES  4   SRAM access length in clocks; legal 3..6 (access + 2 overhead must fit the 8-clock WB slot spacing)
// ADDR_WIDTH     17  SRAM address width
// DATA_WIDTH     8   SRAM data width
// PORTS
// clock_i       in   1   system clock; all logic rises on posedge
// reset_n_i     in   1   asynchronous, active-low reset
// cpu_grant_i   in   1   one-clock CPU slot strobe
// wb_grant_i    in   1   one-clock Wishbone slot strobe
// cpu_addr_i    in   AW  CPU address, sampled on cpu_grant_i
// cpu_we_i      in   1   CPU write, sampled on cpu_grant_i
// cpu_data_i    in   DW  CPU write data, sampled on cpu_grant_i
// cpu_data_o    out  DW  CPU read data, held until next CPU read completes
// cpu_done_o    out  1   one-clock pulse when CPU access completes
// mN_cyc_i/mN_stb_i/mN_we_i  in 1   Wishbone classic request, N in {0,1}
// mN_adr_i      in   AW  Wishbone address
// mN_dat_i      in   DW  Wishbone write data
// mN_ack_o      out  1   one-clock acknowledge
// wb_dat_o      out  DW  Wishbone read data (shared by both masters; valid with ack)
// ram_addr_o    out  AW  SRAM address
// ram_data_o    out  DW  SRAM write data
// ram_data_i    in   DW  SRAM read data
// ram_oe_n_o    out  1   SRAM output enable, active-low
// ram_we_n_o    out  1   SRAM write enable, active-low
// busy_o        out  1   high whenever FSM is not IDLE
// overrun_o     out  1   sticky: a grant strobe arrived while busy
// BEHAVIOUR
// - Reset (async, any state): FSM IDLE; ram_oe_n_o=1, ram_we_n_o=1; ram_addr_o, ram_data_o, cpu_data_o, wb_dat_o = 0;
//   all acks, cpu_done_o, busy_o, overrun_o = 0; round-robin pointer = m0. An in-flight access is abandoned, no ack/done.
// - States: IDLE -> ACCESS (counter 0..ACCESS_CYCLES-1) -> DONE (1 clock) -> IDLE. All outputs registered.
// - Grant seen at edge T: address/data/we/owner latched; ACCESS occupies T+1..T+N (N=ACCESS_CYCLES);
//   read data captured from ram_data_i at end of count N-1; done/ack high during T+N+1 (DONE); IDLE at T+N+2.
// - Read: ram_oe_n_o low for all ACCESS clocks; ram_we_n_o high.
// - Write: ram_oe_n_o high; ram_data_o driven all ACCESS clocks; ram_we_n_o low for counts 1..N-2 only.
// - Outside ACCESS: ram_oe_n_o=ram_we_n_o=1; ram_addr_o/ram_data_o hold last value.
// - cpu_grant_i in IDLE: CPU access always starts (no request handshake).
// - wb_grant_i in IDLE: eligible master = cyc&stb high. Both eligible: pointer selects; one eligible: that master;
//   none: slot unused, stay IDLE. Pointer moves to the other master after each served WB access.
// - Both strobes in the same IDLE clock: CPU wins; WB strobe discarded, not an overrun.
// - Any strobe while not IDLE: ignored, overrun_o set (cleared only by reset).
// - Abort: if owning master drops cyc or stb before DONE, SRAM cycle completes unchanged but no ack issued;
//   wb_dat_o still updated for reads.
// - mN_ack_o only to the owning master, and only if its cyc&stb are high in DONE.
// - Wishbone address/data used are those latched at grant; later changes are ignored.
// TESTING
// - CPU read: mem[0x1234]=0xA5, cpu_grant_i with cpu_addr_i=0x1234, we=0 -> oe_n low 4 clks, cpu_done_o at T+5, cpu_data_o=0xA5.
// - M0 write: m0 writes 0x3C to 0x1FFFF, wb_grant_i -> we_n low clocks T+2..T+3 only; m0_ack_o one clk at T+5; mem updated.
// - Round-robin: m0 and m1 both hold requests over two WB slots -> m0 acked first, m1 second; m1 never acked twice in a row.
// - Collision: cpu_grant_i and wb_grant_i same clock, m0 pending -> CPU served; m0 unacked until next WB slot; overrun_o=0.
// - Overrun: wb_grant_i 2 clocks after cpu_grant_i -> ignored, overrun_o=1 and stays 1.
// - Reset mid-access: reset_n_i low at count 2 of a write -> we_n/oe_n=1 immediately, no ack; next grant runs normally.

Source files
------------

// File: rtl/ram_arbiter_if.sv
`timescale 1ns/1ps
// Bus bundle of the SRAM arbiter: scheduler strobes, CPU port, two Wishbone
// classic masters and the SRAM pins. The arbiter binds to the slave modport;
// whoever drives the strobes, masters and SRAM read data uses the master modport.
//
// Handshake: a Wishbone master requests by holding cyc&stb high and keeps it
// high until its one-clock ack; a request is only taken on a WB slot strobe.
// The CPU has no request line: every CPU slot strobe starts an access and
// cpu_done_o pulses for one clock when it completes.
interface ram_arbiter_if #(
    parameter int AW = 17,
    parameter int DW = 8
);
    logic          cpu_grant_i;
    logic          wb_grant_i;
    logic [AW-1:0] cpu_addr_i;
    logic          cpu_we_i;
    logic [DW-1:0] cpu_data_i;
    logic [DW-1:0] cpu_data_o;
    logic          cpu_done_o;
    logic          m0_cyc_i;
    logic          m0_stb_i;
    logic          m0_we_i;
    logic [AW-1:0] m0_adr_i;
    logic [DW-1:0] m0_dat_i;
    logic          m0_ack_o;
    logic          m1_cyc_i;
    logic          m1_stb_i;
    logic          m1_we_i;
    logic [AW-1:0] m1_adr_i;
    logic [DW-1:0] m1_dat_i;
    logic          m1_ack_o;
    logic [DW-1:0] wb_dat_o;
    logic [AW-1:0] ram_addr_o;
    logic [DW-1:0] ram_data_o;
    logic [DW-1:0] ram_data_i;
    logic          ram_oe_n_o;
    logic          ram_we_n_o;
    logic          busy_o;
    logic          overrun_o;

    modport slave (
        input  cpu_grant_i, wb_grant_i,
        input  cpu_addr_i, cpu_we_i, cpu_data_i,
        output cpu_data_o, cpu_done_o,
        input  m0_cyc_i, m0_stb_i, m0_we_i, m0_adr_i, m0_dat_i,
        output m0_ack_o,
        input  m1_cyc_i, m1_stb_i, m1_we_i, m1_adr_i, m1_dat_i,
        output m1_ack_o,
        output wb_dat_o,
        output ram_addr_o, ram_data_o,
        input  ram_data_i,
        output ram_oe_n_o, ram_we_n_o,
        output busy_o, overrun_o
    );

    modport master (
        output cpu_grant_i, wb_grant_i,
        output cpu_addr_i, cpu_we_i, cpu_data_i,
        input  cpu_data_o, cpu_done_o,
        output m0_cyc_i, m0_stb_i, m0_we_i, m0_adr_i, m0_dat_i,
        input  m0_ack_o,
        output m1_cyc_i, m1_stb_i, m1_we_i, m1_adr_i, m1_dat_i,
        input  m1_ack_o,
        input  wb_dat_o,
        input  ram_addr_o, ram_data_o,
        output ram_data_i,
        input  ram_oe_n_o, ram_we_n_o,
        input  busy_o, overrun_o
    );
endinterface

// File: rtl/ram_arbiter.sv
`timescale 1ns/1ps
// SRAM port owner. Turns CPU and Wishbone slot strobes from the cycle
// scheduler into fixed-length SRAM cycles: IDLE -> ACCESS (ACCESS_CYCLES
// clocks) -> DONE (1 clock) -> IDLE. Two Wishbone masters share the WB slot
// round-robin. Every output is a register.
// ACCESS_CYCLES must lie in 3..6 so that access plus overhead fits the
// 8-clock WB slot spacing and the write pulse (counts 1..N-2) is non-empty.
module ram_arbiter #(
    parameter int ACCESS_CYCLES = 4,
    parameter int ADDR_WIDTH    = 17,
    parameter int DATA_WIDTH    = 8
) (
    input  logic          clock_i,
    input  logic          reset_n_i,
    ram_arbiter_if.slave  bus,
    output logic [1:0]    dbg_state_o
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_DONE   = 2'd2
    } state_t;

    localparam int CW = 3;
    localparam logic [CW-1:0] LAST_CNT    = CW'(ACCESS_CYCLES - 1);
    localparam logic [CW-1:0] WE_LAST_CNT = CW'(ACCESS_CYCLES - 2);

    // FSM state and access counter
    state_t          r_state;
    state_t          w_state_nxt;
    logic [CW-1:0]   r_cnt;
    logic [CW-1:0]   w_cnt_nxt;
    logic [CW-1:0]   w_cnt_inc;

    // Access context latched at grant
    logic            r_owner_cpu, w_owner_cpu_nxt;
    logic            r_owner_m1,  w_owner_m1_nxt;
    logic            r_we,        w_we_nxt;
    logic            r_abort,     w_abort_nxt;
    logic            r_rr_m1,     w_rr_m1_nxt;

    // Registered outputs
    logic [ADDR_WIDTH-1:0] r_ram_addr, w_ram_addr_nxt;
    logic [DATA_WIDTH-1:0] r_ram_data, w_ram_data_nxt;
    logic                  r_oe_n,     w_oe_n_nxt;
    logic                  r_we_n,     w_we_n_nxt;
    logic [DATA_WIDTH-1:0] r_cpu_data, w_cpu_data_nxt;
    logic                  r_cpu_done, w_cpu_done_nxt;
    logic [DATA_WIDTH-1:0] r_wb_dat,   w_wb_dat_nxt;
    logic                  r_m0_ack,   w_m0_ack_nxt;
    logic                  r_m1_ack,   w_m1_ack_nxt;
    logic                  r_busy,     w_busy_nxt;
    logic                  r_overrun,  w_overrun_nxt;

    // Request decode
    logic                  w_idle;
    logic                  w_m0_req;
    logic                  w_m1_req;
    logic                  w_own_req;
    logic                  w_cpu_start;
    logic                  w_wb_start;
    logic                  w_start;
    logic                  w_pick_m1;
    logic                  w_last;
    logic                  w_sel_we;
    logic [ADDR_WIDTH-1:0] w_sel_addr;
    logic [DATA_WIDTH-1:0] w_sel_data;

    assign w_idle      = (r_state == ST_IDLE);
    assign w_m0_req    = bus.m0_cyc_i & bus.m0_stb_i;
    assign w_m1_req    = bus.m1_cyc_i & bus.m1_stb_i;
    assign w_own_req   = r_owner_m1 ? w_m1_req : w_m0_req;
    // CPU wins a same-clock collision; the WB strobe is then simply dropped.
    assign w_cpu_start = w_idle & bus.cpu_grant_i;
    assign w_wb_start  = w_idle & bus.wb_grant_i & ~bus.cpu_grant_i & (w_m0_req | w_m1_req);
    assign w_start     = w_cpu_start | w_wb_start;
    // With both masters pending the pointer decides, otherwise the lone requester.
    assign w_pick_m1   = (w_m0_req & w_m1_req) ? r_rr_m1 : w_m1_req;
    assign w_last      = (r_state == ST_ACCESS) && (r_cnt == LAST_CNT);
    assign w_cnt_inc   = r_cnt + CW'(1);

    assign w_sel_we    = w_cpu_start ? bus.cpu_we_i   : (w_pick_m1 ? bus.m1_we_i  : bus.m0_we_i);
    assign w_sel_addr  = w_cpu_start ? bus.cpu_addr_i : (w_pick_m1 ? bus.m1_adr_i : bus.m0_adr_i);
    assign w_sel_data  = w_cpu_start ? bus.cpu_data_i : (w_pick_m1 ? bus.m1_dat_i : bus.m0_dat_i);

    // State register and access counter
    always_ff @(posedge clock_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            r_state <= ST_IDLE;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    // Next-state logic: fixed-length access, then one DONE clock
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        case (r_state)
            ST_IDLE: begin
                if (w_start) begin
                    w_state_nxt = ST_ACCESS;
                    w_cnt_nxt   = '0;
                end
            end
            ST_ACCESS: begin
                if (w_last) begin
                    w_state_nxt = ST_DONE;
                    w_cnt_nxt   = '0;
                end else begin
                    w_cnt_nxt   = w_cnt_inc;
                end
            end
            ST_DONE: begin
                w_state_nxt = ST_IDLE;
            end
            default: begin
                w_state_nxt = ST_IDLE;
                w_cnt_nxt   = '0;
            end
        endcase
    end

    // Output logic: next values of the registered outputs and access context
    always_comb begin
        w_owner_cpu_nxt = r_owner_cpu;
        w_owner_m1_nxt  = r_owner_m1;
        w_we_nxt        = r_we;
        w_abort_nxt     = r_abort;
        w_rr_m1_nxt     = r_rr_m1;
        w_ram_addr_nxt  = r_ram_addr;
        w_ram_data_nxt  = r_ram_data;
        w_cpu_data_nxt  = r_cpu_data;
        w_wb_dat_nxt    = r_wb_dat;
        w_oe_n_nxt      = 1'b1;
        w_we_n_nxt      = 1'b1;
        w_cpu_done_nxt  = 1'b0;
        w_m0_ack_nxt    = 1'b0;
        w_m1_ack_nxt    = 1'b0;
        w_busy_nxt      = (w_state_nxt != ST_IDLE);
        // Any strobe outside IDLE is lost; flag it until reset.
        w_overrun_nxt   = r_overrun | (~w_idle & (bus.cpu_grant_i | bus.wb_grant_i));

        case (r_state)
            ST_IDLE: begin
                if (w_start) begin
                    w_owner_cpu_nxt = w_cpu_start;
                    w_owner_m1_nxt  = w_cpu_start ? 1'b0 : w_pick_m1;
                    w_we_nxt        = w_sel_we;
                    w_abort_nxt     = 1'b0;
                    w_ram_addr_nxt  = w_sel_addr;
                    if (w_sel_we) begin
                        w_ram_data_nxt = w_sel_data;
                    end
                    // Count 0: output enable for reads, write strobe not yet.
                    w_oe_n_nxt      = w_sel_we;
                end
                if (w_wb_start) begin
                    w_rr_m1_nxt = ~w_pick_m1;
                end
            end
            ST_ACCESS: begin
                // A WB owner that lets go of cyc&stb loses its ack for good.
                w_abort_nxt = r_abort | (~r_owner_cpu & ~w_own_req);
                if (!w_last) begin
                    w_oe_n_nxt = r_we;
                    // Write strobe sits inside the access: counts 1..N-2.
                    w_we_n_nxt = ~(r_we && (w_cnt_inc <= WE_LAST_CNT));
                end else begin
                    if (!r_we) begin
                        if (r_owner_cpu) begin
                            w_cpu_data_nxt = bus.ram_data_i;
                        end else begin
                            w_wb_dat_nxt   = bus.ram_data_i;
                        end
                    end
                    w_cpu_done_nxt = r_owner_cpu;
                    if (!r_owner_cpu && !r_abort && w_own_req) begin
                        w_m0_ack_nxt = ~r_owner_m1;
                        w_m1_ack_nxt = r_owner_m1;
                    end
                end
            end
            default: begin
            end
        endcase
    end

    // Output and context registers
    always_ff @(posedge clock_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            r_owner_cpu <= 1'b0;
            r_owner_m1  <= 1'b0;
            r_we        <= 1'b0;
            r_abort     <= 1'b0;
            r_rr_m1     <= 1'b0;
            r_ram_addr  <= '0;
            r_ram_data  <= '0;
            r_oe_n      <= 1'b1;
            r_we_n      <= 1'b1;
            r_cpu_data  <= '0;
            r_cpu_done  <= 1'b0;
            r_wb_dat    <= '0;
            r_m0_ack    <= 1'b0;
            r_m1_ack    <= 1'b0;
            r_busy      <= 1'b0;
            r_overrun   <= 1'b0;
        end else begin
            r_owner_cpu <= w_owner_cpu_nxt;
            r_owner_m1  <= w_owner_m1_nxt;
            r_we        <= w_we_nxt;
            r_abort     <= w_abort_nxt;
            r_rr_m1     <= w_rr_m1_nxt;
            r_ram_addr  <= w_ram_addr_nxt;
            r_ram_data  <= w_ram_data_nxt;
            r_oe_n      <= w_oe_n_nxt;
            r_we_n      <= w_we_n_nxt;
            r_cpu_data  <= w_cpu_data_nxt;
            r_cpu_done  <= w_cpu_done_nxt;
            r_wb_dat    <= w_wb_dat_nxt;
            r_m0_ack    <= w_m0_ack_nxt;
            r_m1_ack    <= w_m1_ack_nxt;
            r_busy      <= w_busy_nxt;
            r_overrun   <= w_overrun_nxt;
        end
    end

    assign bus.ram_addr_o = r_ram_addr;
    assign bus.ram_data_o = r_ram_data;
    assign bus.ram_oe_n_o = r_oe_n;
    assign bus.ram_we_n_o = r_we_n;
    assign bus.cpu_data_o = r_cpu_data;
    assign bus.cpu_done_o = r_cpu_done;
    assign bus.wb_dat_o   = r_wb_dat;
    assign bus.m0_ack_o   = r_m0_ack;
    assign bus.m1_ack_o   = r_m1_ack;
    assign bus.busy_o     = r_busy;
    assign bus.overrun_o  = r_overrun;
    assign dbg_state_o    = r_state;

endmodule

// File: tb/tb_ram_arbiter.sv
`timescale 1ns/1ps
// Directed bench for ram_arbiter with a behavioural SRAM model.
module tb_ram_arbiter;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [1:0] dbg_state;
    int         checks   = 0;
    int         failures = 0;

    logic [7:0] mem [0:131071];

    ram_arbiter_if #(.AW(17), .DW(8)) bus ();

    ram_arbiter #(
        .ACCESS_CYCLES(4),
        .ADDR_WIDTH(17),
        .DATA_WIDTH(8)
    ) dut (
        .clock_i(clk),
        .reset_n_i(rst_n),
        .bus(bus),
        .dbg_state_o(dbg_state)
    );

    // Clock
    always #5 clk = ~clk;

    // SRAM model: asynchronous read, write sampled on clock while we_n is low
    assign bus.ram_data_i = mem[bus.ram_addr_o];
    always @(posedge clk) begin
        if (!bus.ram_we_n_o) mem[bus.ram_addr_o] = bus.ram_data_o;
    end

    // Driver: reset with all inputs idle
    task automatic do_reset();
        rst_n = 1'b0;
        bus.cpu_grant_i = 0; bus.wb_grant_i = 0;
        bus.cpu_addr_i = '0; bus.cpu_we_i = 0; bus.cpu_data_i = '0;
        bus.m0_cyc_i = 0; bus.m0_stb_i = 0; bus.m0_we_i = 0; bus.m0_adr_i = '0; bus.m0_dat_i = '0;
        bus.m1_cyc_i = 0; bus.m1_stb_i = 0; bus.m1_we_i = 0; bus.m1_adr_i = '0; bus.m1_dat_i = '0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    // Driver: one-clock slot strobe; returns at the negedge of clock T+1
    task automatic strobe(input logic c, input logic w);
        @(negedge clk);
        bus.cpu_grant_i = c;
        bus.wb_grant_i  = w;
        @(negedge clk);
        bus.cpu_grant_i = 1'b0;
        bus.wb_grant_i  = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        rst_n = 1'b0;
        #1;
        checks++; if ({bus.ram_oe_n_o, bus.ram_we_n_o} !== 2'b11) begin failures++; $display("FAIL reset_strobes got=%b exp=11", {bus.ram_oe_n_o, bus.ram_we_n_o}); end
        checks++; if (bus.ram_addr_o !== 17'h0) begin failures++; $display("FAIL reset_addr got=%h exp=0", bus.ram_addr_o); end
        checks++; if ({bus.ram_data_o, bus.cpu_data_o, bus.wb_dat_o} !== 24'h0) begin failures++; $display("FAIL reset_data got=%h exp=0", {bus.ram_data_o, bus.cpu_data_o, bus.wb_dat_o}); end
        checks++; if ({bus.cpu_done_o, bus.m0_ack_o, bus.m1_ack_o, bus.busy_o, bus.overrun_o} !== 5'b0) begin failures++; $display("FAIL reset_flags got=%b exp=00000", {bus.cpu_done_o, bus.m0_ack_o, bus.m1_ack_o, bus.busy_o, bus.overrun_o}); end
        checks++; if (dbg_state !== 2'd0) begin failures++; $display("FAIL reset_state got=%0d exp=0", dbg_state); end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_cpu_read();
        mem[17'h1234] = 8'hA5;
        bus.cpu_addr_i = 17'h1234; bus.cpu_we_i = 1'b0;
        strobe(1'b1, 1'b0);
        for (int k = 1; k <= 6; k++) begin
            if (k > 1) @(negedge clk);
            checks++; if (bus.ram_oe_n_o !== ((k <= 4) ? 1'b0 : 1'b1)) begin failures++; $display("FAIL cpu_read_oe k=%0d got=%b exp=%b", k, bus.ram_oe_n_o, (k <= 4) ? 1'b0 : 1'b1); end
            checks++; if (bus.ram_we_n_o !== 1'b1) begin failures++; $display("FAIL cpu_read_we k=%0d got=%b exp=1", k, bus.ram_we_n_o); end
            checks++; if (bus.cpu_done_o !== (k == 5)) begin failures++; $display("FAIL cpu_read_done k=%0d got=%b exp=%b", k, bus.cpu_done_o, k == 5); end
            checks++; if (bus.busy_o !== (k <= 5)) begin failures++; $display("FAIL cpu_read_busy k=%0d got=%b exp=%b", k, bus.busy_o, k <= 5); end
            if (k == 1) begin
                checks++; if (bus.ram_addr_o !== 17'h1234) begin failures++; $display("FAIL cpu_read_addr got=%h exp=1234", bus.ram_addr_o); end
            end
        end
        checks++; if (bus.cpu_data_o !== 8'hA5) begin failures++; $display("FAIL cpu_read_data got=%h exp=a5", bus.cpu_data_o); end
        checks++; if (bus.overrun_o !== 1'b0) begin failures++; $display("FAIL cpu_read_overrun got=%b exp=0", bus.overrun_o); end
    endtask

    task automatic test_cpu_write_readback();
        bus.cpu_addr_i = 17'h0100; bus.cpu_we_i = 1'b1; bus.cpu_data_i = 8'h5A;
        strobe(1'b1, 1'b0);
        for (int k = 1; k <= 6; k++) begin
            if (k > 1) @(negedge clk);
            checks++; if (bus.ram_we_n_o !== ((k == 2 || k == 3) ? 1'b0 : 1'b1)) begin failures++; $display("FAIL cpu_write_we k=%0d got=%b", k, bus.ram_we_n_o); end
        end
        checks++; if (mem[17'h0100] !== 8'h5A) begin failures++; $display("FAIL cpu_write_mem got=%h exp=5a", mem[17'h0100]); end
        bus.cpu_we_i = 1'b0;
        strobe(1'b1, 1'b0);
        repeat (5) @(negedge clk);
        checks++; if (bus.cpu_data_o !== 8'h5A) begin failures++; $display("FAIL cpu_readback got=%h exp=5a", bus.cpu_data_o); end
    endtask

    task automatic test_m0_write();
        do_reset();
        bus.m0_cyc_i = 1; bus.m0_stb_i = 1; bus.m0_we_i = 1;
        bus.m0_adr_i = 17'h1FFFF; bus.m0_dat_i = 8'h3C;
        strobe(1'b0, 1'b1);
        for (int k = 1; k <= 6; k++) begin
            if (k > 1) @(negedge clk);
            checks++; if (bus.ram_we_n_o !== ((k == 2 || k == 3) ? 1'b0 : 1'b1)) begin failures++; $display("FAIL m0_write_we k=%0d got=%b", k, bus.ram_we_n_o); end
            checks++; if (bus.ram_oe_n_o !== 1'b1) begin failures++; $display("FAIL m0_write_oe k=%0d got=%b exp=1", k, bus.ram_oe_n_o); end
            checks++; if (bus.m0_ack_o !== (k == 5)) begin failures++; $display("FAIL m0_write_ack k=%0d got=%b exp=%b", k, bus.m0_ack_o, k == 5); end
            checks++; if (bus.m1_ack_o !== 1'b0) begin failures++; $display("FAIL m0_write_m1ack k=%0d got=%b exp=0", k, bus.m1_ack_o); end
            if (k == 1) begin
                // Later bus changes must not reach the SRAM.
                bus.m0_adr_i = 17'h0; bus.m0_dat_i = 8'hFF;
            end
            if (k == 3) begin
                checks++; if ({bus.ram_addr_o, bus.ram_data_o} !== {17'h1FFFF, 8'h3C}) begin failures++; $display("FAIL m0_write_latched got=%h/%h exp=1ffff/3c", bus.ram_addr_o, bus.ram_data_o); end
            end
        end
        checks++; if (mem[17'h1FFFF] !== 8'h3C) begin failures++; $display("FAIL m0_write_mem got=%h exp=3c", mem[17'h1FFFF]); end
        bus.m0_cyc_i = 0; bus.m0_stb_i = 0; bus.m0_we_i = 0;
    endtask

    task automatic test_round_robin();
        logic [7:0] exp_dat;
        logic       exp_m1;
        do_reset();
        mem[17'h10] = 8'h11; mem[17'h20] = 8'h22;
        bus.m0_cyc_i = 1; bus.m0_stb_i = 1; bus.m0_adr_i = 17'h10;
        bus.m1_cyc_i = 1; bus.m1_stb_i = 1; bus.m1_adr_i = 17'h20;
        for (int s = 0; s < 3; s++) begin
            exp_m1  = (s == 1);
            exp_dat = exp_m1 ? 8'h22 : 8'h11;
            strobe(1'b0, 1'b1);
            for (int k = 1; k <= 6; k++) begin
                if (k > 1) @(negedge clk);
                checks++; if (bus.m0_ack_o !== (k == 5 && !exp_m1)) begin failures++; $display("FAIL rr_m0_ack slot=%0d k=%0d got=%b", s, k, bus.m0_ack_o); end
                checks++; if (bus.m1_ack_o !== (k == 5 && exp_m1)) begin failures++; $display("FAIL rr_m1_ack slot=%0d k=%0d got=%b", s, k, bus.m1_ack_o); end
                if (k == 5) begin
                    checks++; if (bus.wb_dat_o !== exp_dat) begin failures++; $display("FAIL rr_dat slot=%0d got=%h exp=%h", s, bus.wb_dat_o, exp_dat); end
                end
            end
        end
        bus.m0_cyc_i = 0; bus.m0_stb_i = 0; bus.m1_cyc_i = 0; bus.m1_stb_i = 0;
    endtask

    task automatic test_collision();
        do_reset();
        mem[17'h10] = 8'h11;
        bus.cpu_addr_i = 17'h1234; bus.cpu_we_i = 1'b0;
        bus.m0_cyc_i = 1; bus.m0_stb_i = 1; bus.m0_we_i = 0; bus.m0_adr_i = 17'h10;
        strobe(1'b1, 1'b1);
        for (int k = 1; k <= 6; k++) begin
            if (k > 1) @(negedge clk);
            checks++; if (bus.cpu_done_o !== (k == 5)) begin failures++; $display("FAIL coll_done k=%0d got=%b exp=%b", k, bus.cpu_done_o, k == 5); end
            checks++; if (bus.m0_ack_o !== 1'b0) begin failures++; $display("FAIL coll_m0_ack k=%0d got=%b exp=0", k, bus.m0_ack_o); end
        end
        checks++; if (bus.overrun_o !== 1'b0) begin failures++; $display("FAIL coll_overrun got=%b exp=0", bus.overrun_o); end
        strobe(1'b0, 1'b1);
        for (int k = 1; k <= 6; k++) begin
            if (k > 1) @(negedge clk);
            checks++; if (bus.m0_ack_o !== (k == 5)) begin failures++; $display("FAIL coll_next_ack k=%0d got=%b exp=%b", k, bus.m0_ack_o, k == 5); end
        end
        checks++; if (bus.wb_dat_o !== 8'h11) begin failures++; $display("FAIL coll_next_dat got=%h exp=11", bus.wb_dat_o); end
        bus.m0_cyc_i = 0; bus.m0_stb_i = 0;
    endtask

    task automatic test_overrun();
        do_reset();
        bus.cpu_addr_i = 17'h1234; bus.cpu_we_i = 1'b0;
        bus.m0_cyc_i = 1; bus.m0_stb_i = 1; bus.m0_adr_i = 17'h10;
        strobe(1'b1, 1'b0);
        for (int k = 1; k <= 10; k++) begin
            if (k > 1) @(negedge clk);
            if (k == 2) begin
                checks++; if (bus.overrun_o !== 1'b0) begin failures++; $display("FAIL ovr_before got=%b exp=0", bus.overrun_o); end
                bus.wb_grant_i = 1'b1;
            end
            if (k == 3) bus.wb_grant_i = 1'b0;
            if (k >= 3) begin
                checks++; if (bus.overrun_o !== 1'b1) begin failures++; $display("FAIL ovr_sticky k=%0d got=%b exp=1", k, bus.overrun_o); end
            end
            checks++; if (bus.m0_ack_o !== 1'b0) begin failures++; $display("FAIL ovr_m0_ack k=%0d got=%b exp=0", k, bus.m0_ack_o); end
        end
        checks++; if (bus.busy_o !== 1'b0) begin failures++; $display("FAIL ovr_idle got=%b exp=0", bus.busy_o); end
        bus.m0_cyc_i = 0; bus.m0_stb_i = 0;
    endtask

    task automatic test_abort();
        do_reset();
        mem[17'h20] = 8'h22;
        bus.m1_cyc_i = 1; bus.m1_stb_i = 1; bus.m1_we_i = 0; bus.m1_adr_i = 17'h20;
        strobe(1'b0, 1'b1);
        for (int k = 1; k <= 6; k++) begin
            if (k > 1) @(negedge clk);
            checks++; if (bus.ram_oe_n_o !== ((k <= 4) ? 1'b0 : 1'b1)) begin failures++; $display("FAIL abort_oe k=%0d got=%b", k, bus.ram_oe_n_o); end
            checks++; if ({bus.m0_ack_o, bus.m1_ack_o} !== 2'b00) begin failures++; $display("FAIL abort_ack k=%0d got=%b exp=00", k, {bus.m0_ack_o, bus.m1_ack_o}); end
            if (k == 2) bus.m1_stb_i = 1'b0;
        end
        checks++; if (bus.wb_dat_o !== 8'h22) begin failures++; $display("FAIL abort_dat got=%h exp=22", bus.wb_dat_o); end
        bus.m1_cyc_i = 0;
    endtask

    task automatic test_reset_mid();
        do_reset();
        bus.m0_cyc_i = 1; bus.m0_stb_i = 1; bus.m0_we_i = 1;
        bus.m0_adr_i = 17'h40; bus.m0_dat_i = 8'h77;
        strobe(1'b0, 1'b1);
        @(negedge clk);
        @(negedge clk);
        checks++; if (bus.ram_we_n_o !== 1'b0) begin failures++; $display("FAIL mid_we_before got=%b exp=0", bus.ram_we_n_o); end
        rst_n = 1'b0;
        #1;
        checks++; if ({bus.ram_we_n_o, bus.ram_oe_n_o} !== 2'b11) begin failures++; $display("FAIL mid_strobes got=%b exp=11", {bus.ram_we_n_o, bus.ram_oe_n_o}); end
        checks++; if ({bus.busy_o, dbg_state} !== 3'b000) begin failures++; $display("FAIL mid_state got=%b exp=000", {bus.busy_o, dbg_state}); end
        @(negedge clk);
        rst_n = 1'b1;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            checks++; if ({bus.m0_ack_o, bus.busy_o} !== 2'b00) begin failures++; $display("FAIL mid_quiet k=%0d got=%b exp=00", k, {bus.m0_ack_o, bus.busy_o}); end
        end
        bus.m0_adr_i = 17'h41; bus.m0_dat_i = 8'h55;
        strobe(1'b0, 1'b1);
        for (int k = 1; k <= 6; k++) begin
            if (k > 1) @(negedge clk);
            checks++; if (bus.m0_ack_o !== (k == 5)) begin failures++; $display("FAIL mid_next_ack k=%0d got=%b exp=%b", k, bus.m0_ack_o, k == 5); end
        end
        checks++; if (mem[17'h41] !== 8'h55) begin failures++; $display("FAIL mid_next_mem got=%h exp=55", mem[17'h41]); end
        bus.m0_cyc_i = 0; bus.m0_stb_i = 0; bus.m0_we_i = 0;
    endtask

    // Sequence and report
    initial begin
        test_reset();
        test_cpu_read();
        test_cpu_write_readback();
        test_m0_write();
        test_round_robin();
        test_collision();
        test_overrun();
        test_abort();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
